// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller.
// Contents:
//   state_t        4-bit FSM state encoding
//   Op*            instruction class codes
//   Res*/SrcA*/SrcB* datapath multiplexer select codes
//   ctrl_t         bundle of the registered datapath controls
//   ctrl_decode()  Moore output table: controls as a function of state only
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StExecI   = 4'd7,
    StAluWb   = 4'd8,
    StBranch  = 4'd9,
    StMcStart = 4'd10,
    StMcWait  = 4'd11,
    StMcWb    = 4'd12
  } state_t;

  // Instruction classes
  localparam logic [1:0] OpData   = 2'b00;
  localparam logic [1:0] OpMem    = 2'b01;
  localparam logic [1:0] OpBranch = 2'b10;
  localparam logic [1:0] OpUndef  = 2'b11;

  // ResultSrc selects
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResReadData  = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;
  localparam logic [1:0] ResMul       = 2'b11;

  // ALUSrcA selects
  localparam logic [1:0] SrcAReg = 2'b00;
  localparam logic [1:0] SrcAPc  = 2'b01;

  // ALUSrcB selects
  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       mem_w;
    logic       reg_w;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic       start;
  } ctrl_t;

  // Unlisted controls stay 0; unused codes 13-15 decode to all-zero.
  function automatic ctrl_t ctrl_decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = SrcAPc;
        c.alu_src_b  = SrcBFour;
        c.result_src = ResAluResult;
      end
      StDecode: begin
        c.alu_src_a  = SrcAPc;
        c.alu_src_b  = SrcBFour;
        c.result_src = ResAluResult;
      end
      StMemAdr: c.alu_src_b = SrcBImm;
      StMemRd:  c.adr_src = 1'b1;
      StMemWb: begin
        c.result_src = ResReadData;
        c.reg_w      = 1'b1;
      end
      StMemWr: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      StExecR: begin
        c.alu_op    = 1'b1;
        c.alu_src_b = SrcBReg;
      end
      StExecI: begin
        c.alu_op    = 1'b1;
        c.alu_src_b = SrcBImm;
      end
      StAluWb: begin
        c.result_src = ResAluOut;
        c.reg_w      = 1'b1;
      end
      StBranch: begin
        c.alu_src_b  = SrcBImm;
        c.result_src = ResAluResult;
        c.branch     = 1'b1;
      end
      StMcStart: c.start = 1'b1;
      StMcWb: begin
        c.result_src = ResMul;
        c.reg_w      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mcycle_seq.sv
// Multi-cycle unit handshake sequencer (MCSTART -> MCWAIT -> MCWB -> FETCH).
// Only instantiated when MULTICYCLE_CTRL_MCYCLE_EN is defined.
// Ports:
//   state  in   current controller state
//   busy   in   multi-cycle unit busy
//   next   out  next state while in one of the multi-cycle states
module mcycle_seq
  import multicycle_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   busy,
  output state_t next
);

  always_comb begin
    next = StFetch;
    case (state)
      StMcStart: next = StMcWait;
      // Launch pulse lasts one cycle; then wait for the unit to drop busy.
      StMcWait:  next = busy ? StMcWait : StMcWb;
      StMcWb:    next = StFetch;
      default:   next = StFetch;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor main controller (Moore FSM).
// Optional feature: define MULTICYCLE_CTRL_MCYCLE_EN to add the multiply/divide
// launch path (states MCSTART/MCWAIT/MCWB, Start output, IsMul/Busy inputs).
// Ports:
//   CLK, RESET                clock, asynchronous active-high reset
//   Op, Funct, CondEx, IsMul  instruction decode inputs, sampled in DECODE/MEMADR
//   Busy                      multi-cycle unit busy
//   NextPC..ALUOp             datapath enables and selects (registered)
//   Start                     one-cycle launch pulse to the multi-cycle unit
//   Illegal                   undefined instruction seen in DECODE
//   State                     current state code, for debug
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       CondEx,
  input  logic       IsMul,
  input  logic       Busy,
  output logic       NextPC,
  output logic       Branch,
  output logic       MemW,
  output logic       RegW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic       Start,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

`ifdef MULTICYCLE_CTRL_MCYCLE_EN
  state_t mc_next;

  mcycle_seq u_mcycle_seq (
    .state (state_q),
    .busy  (Busy),
    .next  (mc_next)
  );
`endif

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        if (!CondEx) begin
          state_d = StFetch;
        end else begin
          case (Op)
            OpMem:    state_d = StMemAdr;
`ifdef MULTICYCLE_CTRL_MCYCLE_EN
            OpData:   state_d = IsMul     ? StMcStart :
                                Funct[5]  ? StExecI   : StExecR;
`else
            OpData:   state_d = Funct[5] ? StExecI : StExecR;
`endif
            OpBranch: state_d = StBranch;
            default:  state_d = StFetch;
          endcase
        end
      end
      StMemAdr: state_d = Funct[0] ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = StFetch;
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
`ifdef MULTICYCLE_CTRL_MCYCLE_EN
      StMcStart, StMcWait, StMcWb: state_d = mc_next;
`endif
      // Unused codes (and the multi-cycle codes when that path is absent) recover to FETCH.
      default:  state_d = StFetch;
    endcase
  end

  // Controls are registered from the next state, so they remain a pure function of the
  // state register while coming straight from flops.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StFetch;
      ctrl_q  <= ctrl_decode(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_decode(state_d);
    end
  end

  assign NextPC    = ctrl_q.next_pc;
  assign Branch    = ctrl_q.branch;
  assign MemW      = ctrl_q.mem_w;
  assign RegW      = ctrl_q.reg_w;
  assign IRWrite   = ctrl_q.ir_write;
  assign AdrSrc    = ctrl_q.adr_src;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ALUOp     = ctrl_q.alu_op;
  assign State     = state_q;

  // Illegal has to flag the instruction during DECODE itself, where Op is only now
  // valid, so it is decoded combinationally. A condition-failed instruction is squashed
  // before it is classified and never flags.
  assign Illegal = (state_q == StDecode) && CondEx && (Op == OpUndef);

`ifdef MULTICYCLE_CTRL_MCYCLE_EN
  assign Start = ctrl_q.start;
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];
`else
  assign Start = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{Funct[4:1], IsMul, Busy, ctrl_q.start};
`endif

endmodule
